// File: rtl/afifo_byte_reader_pkg.sv
// Shared constants for the AFIFO byte reader: FIFO word geometry and FSM state encoding.
package afifo_byte_reader_pkg;

  localparam int unsigned WordW = 16;
  localparam int unsigned ByteW = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HIGH = 3'd2,
    ST_LOW  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/afifo_byte_reader.sv
// Pulls a chunk of 16-bit words from an AFIFO read port and streams them out
// high byte first, prefetching the next word so a ready sink sees one byte per cycle.
module afifo_byte_reader
  import afifo_byte_reader_pkg::*;
#(
  parameter int unsigned CountW = 16
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              start_trigger,
  input  logic [CountW-1:0] chunk_words,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              fifo_trigger,
  input  logic [WordW-1:0]  fifo_data,
  input  logic              fifo_ready,
  output logic [ByteW-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  state_t              state;
  logic [CountW-1:0]   remaining;
  logic [WordW-1:0]    word;
  logic                more_c;

  // FIFO pop must coincide with fifo_ready in the same cycle, so it is decoded combinationally.
  always_comb begin
    more_c       = remaining > CountW'(1);
    fifo_trigger = 1'b0;
    if (!abort && fifo_ready) begin
      case (state)
        ST_LOAD: fifo_trigger = 1'b1;
        ST_LOW:  fifo_trigger = out_ready && more_c;
        default: fifo_trigger = 1'b0;
      endcase
    end
  end

  // Outputs are loaded on each transition with the values of the state being entered.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= ST_IDLE;
      remaining <= '0;
      word      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (abort && state != ST_IDLE) begin
      state     <= ST_IDLE;
      remaining <= '0;
      word      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_trigger) begin
            busy <= 1'b1;
            if (chunk_words != '0) begin
              remaining <= chunk_words;
              state     <= ST_LOAD;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_LOAD: begin
          if (fifo_trigger) begin
            word      <= fifo_data;
            out_data  <= fifo_data[WordW-1 -: ByteW];
            out_valid <= 1'b1;
            state     <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (out_ready) begin
            out_data <= word[ByteW-1:0];
            state    <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (out_ready) begin
            remaining <= remaining - CountW'(1);
            if (!more_c) begin
              done      <= 1'b1;
              out_valid <= 1'b0;
              out_data  <= '0;
              state     <= ST_DONE;
            end else if (fifo_trigger) begin
              word     <= fifo_data;
              out_data <= fifo_data[WordW-1 -: ByteW];
              state    <= ST_HIGH;
            end else begin
              out_valid <= 1'b0;
              out_data  <= '0;
              state     <= ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_afifo_byte_reader.sv
// Self-checking bench: queue-based FIFO and byte-stream model, directed scenarios plus randomized chunks.
module tb_afifo_byte_reader;

  localparam int unsigned CountW = 16;

  logic              clk = 1'b0;
  logic              rst_;
  logic              start_trigger;
  logic [CountW-1:0] chunk_words;
  logic              abort;
  logic              busy;
  logic              done;
  logic              fifo_trigger;
  logic [15:0]       fifo_data;
  logic              fifo_ready;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;

  always #5 clk = ~clk;

  afifo_byte_reader #(.CountW(CountW)) dut (
    .clk           (clk),
    .rst_          (rst_),
    .start_trigger (start_trigger),
    .chunk_words   (chunk_words),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .fifo_trigger  (fifo_trigger),
    .fifo_data     (fifo_data),
    .fifo_ready    (fifo_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO model: everything ever pushed, plus a read pointer advanced on each pop.
  logic [15:0] mem[$];
  int          rd_ptr = 0;

  // Per-chunk observations of the byte stream.
  logic [7:0]  got_q[$];
  int          xfer_cyc[$];
  int          done_cnt, trig_cnt, done_cyc, start_cyc, cyc;
  logic        s_busy, s_valid, s_trig;
  logic [7:0]  s_data;
  bit          p_stall = 1'b0;
  logic [7:0]  p_data;

  task automatic step(input bit st, input logic [15:0] cw, input bit ab, input bit gate, input bit ordy);
    @(negedge clk);
    start_trigger = st;
    chunk_words   = cw;
    abort         = ab;
    out_ready     = ordy;
    fifo_ready    = gate && (rd_ptr < mem.size());
    fifo_data     = (rd_ptr < mem.size()) ? mem[rd_ptr] : 16'h0;
    #1;
    s_busy  = busy;
    s_valid = out_valid;
    s_trig  = fifo_trigger;
    s_data  = out_data;
    if (fifo_trigger) check("trig_needs_ready", 32'(fifo_ready), 32'd1);
    if (p_stall) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'(p_data));
    end
    p_stall = out_valid && !out_ready && !ab;
    p_data  = out_data;
    if (out_valid && out_ready && !ab) begin
      got_q.push_back(out_data);
      xfer_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (fifo_trigger) trig_cnt++;
    @(posedge clk);
    #1;
    if (s_trig) rd_ptr++;
    cyc++;
  endtask

  task automatic start_chunk(input logic [15:0] cw, input bit ab);
    got_q.delete();
    xfer_cyc.delete();
    done_cnt  = 0;
    trig_cnt  = 0;
    done_cyc  = -1;
    start_cyc = cyc;
    step(1'b1, cw, ab, 1'b1, 1'b1);
  endtask

  task automatic run_to_done(input int gate_pct, input int ordy_pct, input bit noise);
    int n = 0;
    while (done_cnt == 0 && n < 500) begin
      step(noise && ($urandom_range(0, 3) == 0), 16'($urandom), 1'b0,
           $urandom_range(1, 100) <= gate_pct, $urandom_range(1, 100) <= ordy_pct);
      n++;
    end
    check("done_seen", 32'(done_cnt), 32'd1);
  endtask

  // Expected stream: each consumed word, high byte then low byte.
  task automatic check_bytes(input int base, input int words);
    logic [15:0] w;
    check("byte_count", 32'(got_q.size()), 32'(2 * words));
    for (int i = 0; i < words; i++) begin
      w = mem[base + i];
      if (2 * i + 1 < got_q.size()) begin
        check("byte_hi", 32'(got_q[2 * i]), 32'(w[15:8]));
        check("byte_lo", 32'(got_q[2 * i + 1]), 32'(w[7:0]));
      end
    end
    check("words_consumed", 32'(rd_ptr - base), 32'(words));
  endtask

  initial begin
    int base, base2, cw;
    cyc           = 0;
    rst_          = 1'b0;
    start_trigger = 1'b0;
    chunk_words   = '0;
    abort         = 1'b0;
    fifo_ready    = 1'b0;
    fifo_data     = '0;
    out_ready     = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_trig", 32'(fifo_trigger), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_ = 1'b1;

    // Three words with everything ready: six bytes back to back.
    base = rd_ptr;
    mem.push_back(16'h1234);
    mem.push_back(16'h5678);
    mem.push_back(16'h9ABC);
    start_chunk(16'd3, 1'b0);
    run_to_done(100, 100, 1'b0);
    check_bytes(base, 3);
    if (xfer_cyc.size() == 6) begin
      check("first_byte_latency", 32'(xfer_cyc[0] - start_cyc), 32'd2);
      check("bytes_consecutive", 32'(xfer_cyc[5] - xfer_cyc[0]), 32'd5);
      check("done_after_last", 32'(done_cyc - xfer_cyc[5]), 32'd1);
    end
    step(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
    check("idle_after_done", 32'(s_busy), 32'd0);

    // FIFO runs dry between words: Load must wait without popping.
    base = rd_ptr;
    mem.push_back(16'h1234);
    start_chunk(16'd2, 1'b0);
    step(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
    mem.push_back(16'h5678);
    step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
      check("load_wait_valid", 32'(s_valid), 32'd0);
      check("load_wait_trig", 32'(s_trig), 32'd0);
    end
    run_to_done(100, 100, 1'b0);
    check_bytes(base, 2);

    // Sink back-pressure on the high byte.
    base = rd_ptr;
    mem.push_back(16'h1234);
    mem.push_back(16'h5678);
    start_chunk(16'd2, 1'b0);
    step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    check("stall_hi_0", 32'(s_data), 32'h12);
    step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    check("stall_hi_1", 32'(s_data), 32'h12);
    step(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
    check("accept_hi", 32'(s_data), 32'h12);
    run_to_done(100, 50, 1'b0);
    check_bytes(base, 2);

    // Empty chunk: straight to Done with no FIFO activity even though data is available.
    mem.push_back(16'hBEEF);
    base = rd_ptr;
    start_chunk(16'd0, 1'b0);
    run_to_done(100, 100, 1'b0);
    check("zero_done_latency", 32'(done_cyc - start_cyc), 32'd1);
    check("zero_no_trig", 32'(trig_cnt), 32'd0);
    check_bytes(base, 0);

    // Abort in the low byte of word 2 of 4; the remaining words stay in the FIFO.
    base = rd_ptr;
    for (int i = 0; i < 3; i++) mem.push_back(16'($urandom));
    start_chunk(16'd4, 1'b0);
    repeat (4) step(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 16'd0, 1'b1, 1'b1, 1'b1);
    check("abort_no_trig", 32'(s_trig), 32'd0);
    step(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
    check("abort_idle", 32'(s_busy), 32'd0);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_words_left", 32'(rd_ptr - base), 32'd2);
    base2 = rd_ptr;
    start_chunk(16'd2, 1'b0);
    run_to_done(100, 100, 1'b0);
    check_bytes(base2, 2);

    // Asynchronous reset while presenting the high byte.
    mem.push_back(16'hA55A);
    mem.push_back(16'h0FF0);
    start_chunk(16'd2, 1'b0);
    step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst_ = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data", 32'(out_data), 32'd0);
    p_stall = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;
    base = rd_ptr;
    start_chunk(16'd1, 1'b0);
    run_to_done(100, 100, 1'b0);
    check_bytes(base, 1);

    // Randomized chunks with FIFO gaps, sink stalls, stray starts while busy and start+abort in Idle.
    repeat (24) begin
      cw = int'($urandom_range(0, 6));
      for (int i = 0; i < cw + int'($urandom_range(0, 1)); i++) mem.push_back(16'($urandom));
      base = rd_ptr;
      start_chunk(16'(cw), 1'($urandom_range(0, 1)));
      run_to_done(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), 1'b1);
      check_bytes(base, cw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
